// File: rtl/cfg_arb_pkg.sv
// rtl/cfg_arb_pkg.sv - shared types and defaults for the config source arbiter
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic SRC_BITBANG = 1'b0;
    localparam logic SRC_UART    = 1'b1;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_FRAME_WORDS    = 20;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    // Counter width able to hold max_count; a 1-bit floor keeps TIMEOUT_CYCLES=0 legal.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/config_source_arbiter_if.sv
// rtl/config_source_arbiter_if.sv - source inputs and forwarded write bus of the arbiter
interface config_source_arbiter_if
    import cfg_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
);
    localparam int IDX_W = $clog2(FRAME_WORDS);

    logic                  src0_strobe;
    logic [DATA_WIDTH-1:0] src0_data;
    logic                  src0_active;
    logic                  src1_strobe;
    logic [DATA_WIDTH-1:0] src1_data;
    logic                  src1_active;

    logic                  write_strobe;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  frame_strobe;
    logic [IDX_W-1:0]      word_index;

    modport master (
        output src0_strobe, src0_data, src0_active,
        output src1_strobe, src1_data, src1_active,
        input  write_strobe, write_data, frame_strobe, word_index
    );

    modport slave (
        input  src0_strobe, src0_data, src0_active,
        input  src1_strobe, src1_data, src1_active,
        output write_strobe, write_data, frame_strobe, word_index
    );

endinterface

// File: rtl/cfg_frame_counter.sv
// rtl/cfg_frame_counter.sv - word position within a frame and end-of-frame pulse
module cfg_frame_counter #(
    parameter int FRAME_WORDS = 20,
    parameter int IDX_W       = $clog2(FRAME_WORDS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] word_index,
    output logic             frame_strobe
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_WORDS - 1);

    logic at_last;
    assign at_last = (word_index == LAST);

    // The last word of a frame still pulses even when the session ends on it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_index   <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= advance && at_last;
            if (clear) begin
                word_index <= '0;
            end else if (advance) begin
                word_index <= at_last ? '0 : word_index + 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_source_arbiter.sv
// rtl/config_source_arbiter.sv - grants the config write port to bitbang (priority) or UART
module config_source_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FRAME_WORDS    = DEF_FRAME_WORDS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    resetn,
    config_source_arbiter_if.slave  bus,
    input  logic                    err_clear,
    output logic                    cfg_active,
    output logic                    owner,
    output logic                    drop_err,
    output logic                    timeout_err
);
    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_t                state, state_next;
    logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_next;
    logic [1:0]            lock, lock_next;
    logic                  fwd, drop_ev, tmo_ev, grant, grant_src;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  own_is1, own_strobe, own_active, other_strobe;
    logic [DATA_WIDTH-1:0] own_data;
    logic [31:0]           cnt_plus;
    logic                  tmo_hit;
    logic                  elig0, elig1;
    logic                  write_strobe_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [IDX_W-1:0]      word_index;
    logic                  frame_strobe;

    assign own_is1      = (state == OWN1);
    assign own_strobe   = own_is1 ? bus.src1_strobe : bus.src0_strobe;
    assign own_active   = own_is1 ? bus.src1_active : bus.src0_active;
    assign own_data     = own_is1 ? bus.src1_data   : bus.src0_data;
    assign other_strobe = own_is1 ? bus.src0_strobe : bus.src1_strobe;

    // A timed-out source stays locked out until its active flag has been seen low.
    assign elig0 = bus.src0_active && !lock[SRC_BITBANG];
    assign elig1 = bus.src1_active && !lock[SRC_UART];

    assign cnt_plus = 32'(tmo_cnt) + 32'd1;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_plus >= 32'(TIMEOUT_CYCLES));

    assign lock_next[SRC_BITBANG] = (tmo_ev && !own_is1) || (lock[SRC_BITBANG] && bus.src0_active);
    assign lock_next[SRC_UART]    = (tmo_ev &&  own_is1) || (lock[SRC_UART]    && bus.src1_active);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fwd          = 1'b0;
        fwd_data     = own_data;
        drop_ev      = 1'b0;
        tmo_ev       = 1'b0;
        grant        = 1'b0;
        grant_src    = SRC_BITBANG;
        tmo_cnt_next = tmo_cnt;
        case (state)
            IDLE: begin
                if (elig0) begin
                    grant        = 1'b1;
                    grant_src    = SRC_BITBANG;
                    state_next   = OWN0;
                    fwd          = bus.src0_strobe;
                    fwd_data     = bus.src0_data;
                    tmo_cnt_next = '0;
                end else if (elig1) begin
                    grant        = 1'b1;
                    grant_src    = SRC_UART;
                    state_next   = OWN1;
                    fwd          = bus.src1_strobe;
                    fwd_data     = bus.src1_data;
                    tmo_cnt_next = '0;
                end
            end
            OWN0, OWN1: begin
                fwd          = own_strobe;
                drop_ev      = other_strobe;
                tmo_cnt_next = own_strobe ? '0 : CNT_W'(cnt_plus);
                if (!own_active) begin
                    state_next = IDLE;
                end else if (!own_strobe && tmo_hit) begin
                    state_next = IDLE;
                    tmo_ev     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt        <= '0;
            lock           <= '0;
            cfg_active     <= 1'b0;
            owner          <= 1'b0;
            write_strobe_q <= 1'b0;
            write_data_q   <= '0;
            drop_err       <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            tmo_cnt        <= tmo_cnt_next;
            lock           <= lock_next;
            cfg_active     <= (state_next != IDLE);
            write_strobe_q <= fwd;
            if (grant) begin
                owner <= grant_src;
            end
            if (fwd) begin
                write_data_q <= fwd_data;
            end
            // A new error event wins over a coincident clear.
            if (drop_ev) begin
                drop_err <= 1'b1;
            end else if (err_clear) begin
                drop_err <= 1'b0;
            end
            if (tmo_ev) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
        end
    end

    cfg_frame_counter #(
        .FRAME_WORDS (FRAME_WORDS),
        .IDX_W       (IDX_W)
    ) u_frame_counter (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (state_next == IDLE),
        .advance      (fwd),
        .word_index   (word_index),
        .frame_strobe (frame_strobe)
    );

    assign bus.write_strobe = write_strobe_q;
    assign bus.write_data   = write_data_q;
    assign bus.frame_strobe = frame_strobe;
    assign bus.word_index   = word_index;

endmodule

// File: tb/tb_config_source_arbiter.sv
// tb/tb_config_source_arbiter.sv - directed bench with a session-level reference model
module tb_config_source_arbiter;
    import cfg_arb_pkg::*;

    localparam int DW  = 32;
    localparam int FW  = 20;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic err_clear = 1'b0;
    logic cfg_active, owner, drop_err, timeout_err;

    config_source_arbiter_if #(.DATA_WIDTH(DW), .FRAME_WORDS(FW)) bus ();

    config_source_arbiter #(
        .DATA_WIDTH     (DW),
        .FRAME_WORDS    (FW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .err_clear   (err_clear),
        .cfg_active  (cfg_active),
        .owner       (owner),
        .drop_err    (drop_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int fs_seen = 0;
    bit chk_en = 1'b0;

    // Session model: m_own is -1 when nobody owns the port, else the owning source.
    int          m_own = -1;
    bit          m_owner = 1'b0;
    bit  [1:0]   m_lk = '0;
    int          m_idle = 0;
    int          m_pos = 0;
    bit          m_ws = 1'b0, m_fs = 1'b0, m_de = 1'b0, m_te = 1'b0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit          stb [2];
        bit          act [2];
        logic [31:0] dat [2];
        bit          drop = 1'b0;
        bit          tmo = 1'b0;
        bit          moved = 1'b0;
        bit          owned_before;
        int          src = -1;
        stb[0] = bus.src0_strobe; dat[0] = bus.src0_data; act[0] = bus.src0_active;
        stb[1] = bus.src1_strobe; dat[1] = bus.src1_data; act[1] = bus.src1_active;
        m_ws = 1'b0;
        m_fs = 1'b0;
        owned_before = (m_own >= 0);
        if (!owned_before) begin
            for (int s = 0; s < 2; s++)
                if (src < 0 && act[s] && !m_lk[s]) src = s;
            if (src >= 0) begin
                m_own = src; m_owner = src[0]; m_idle = 0; m_pos = 0;
                moved = stb[src];
            end
        end else begin
            src = m_own;
            moved = stb[src];
            drop = stb[1 - src];
            if (moved) m_idle = 0; else m_idle++;
        end
        if (moved) begin
            m_ws = 1'b1;
            m_wd = dat[src];
            m_fs = (m_pos == FW - 1);
            m_pos = (m_pos + 1) % FW;
        end
        for (int s = 0; s < 2; s++) if (!act[s]) m_lk[s] = 1'b0;
        if (owned_before) begin
            if (!act[src]) begin
                m_own = -1; m_pos = 0;
            end else if (!moved && m_idle >= TMO) begin
                m_own = -1; m_pos = 0; tmo = 1'b1; m_lk[src] = 1'b1;
            end
        end
        if (err_clear) begin m_de = 1'b0; m_te = 1'b0; end
        if (drop) m_de = 1'b1;
        if (tmo) m_te = 1'b1;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_own = -1; m_owner = 1'b0; m_lk = '0; m_idle = 0; m_pos = 0;
            m_ws = 1'b0; m_fs = 1'b0; m_de = 1'b0; m_te = 1'b0; m_wd = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cfg_active", cfg_active, m_own >= 0);
            if (m_own >= 0) chk("owner", owner, m_owner);
            chk("write_strobe", bus.write_strobe, m_ws);
            chk("write_data", bus.write_data, m_wd);
            chk("frame_strobe", bus.frame_strobe, m_fs);
            chk("word_index", bus.word_index, m_pos);
            chk("drop_err", drop_err, m_de);
            chk("timeout_err", timeout_err, m_te);
            if (bus.frame_strobe) fs_seen++;
        end
    end

    task automatic cyc(input bit a0, input bit s0, input logic [31:0] d0,
                       input bit a1, input bit s1, input logic [31:0] d1, input bit clr);
        @(negedge clk);
        bus.src0_active = a0; bus.src0_strobe = s0; bus.src0_data = d0;
        bus.src1_active = a1; bus.src1_strobe = s1; bus.src1_data = d1;
        err_clear = clr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cfg_active"}, cfg_active, 0);
        chk({tag, " owner"}, owner, 0);
        chk({tag, " write_strobe"}, bus.write_strobe, 0);
        chk({tag, " write_data"}, bus.write_data, 0);
        chk({tag, " frame_strobe"}, bus.frame_strobe, 0);
        chk({tag, " word_index"}, bus.word_index, 0);
        chk({tag, " drop_err"}, drop_err, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int act_cnt;
        bus.src0_strobe = 1'b0; bus.src0_data = '0; bus.src0_active = 1'b0;
        bus.src1_strobe = 1'b0; bus.src1_data = '0; bus.src1_active = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Basic forwarding of one full frame
        for (int i = 1; i <= FW; i++) cyc(1, 1, i, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("basic last data", bus.write_data, 32'h14);
        chk("basic frame_strobe", bus.frame_strobe, 1);
        chk("basic index wrap", bus.word_index, 0);
        chk("basic frame count", fs_seen, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #1 chk("basic released", cfg_active, 0);

        // Priority and non-owner drops
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 32'h11, 0);
        #1;
        chk("prio owner", owner, 0);
        chk("prio active", cfg_active, 1);
        cyc(1, 0, 0, 1, 1, 32'h22, 0);
        cyc(1, 0, 0, 1, 1, 32'h33, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #1;
        chk("prio drop_err", drop_err, 1);
        chk("prio no write", bus.write_strobe, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #1 chk("prio cleared", drop_err, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Handover with a final word in the release cycle
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h100 + i, 1, 0, 0, 0);
        cyc(0, 1, 32'hDEADBEEF, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("hand final data", bus.write_data, 32'hDEADBEEF);
        chk("hand final strobe", bus.write_strobe, 1);
        chk("hand idle", cfg_active, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("hand owner", owner, 1);
        chk("hand index", bus.word_index, 0);
        chk("hand no frame", fs_seen, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Inactivity timeout and lockout
        act_cnt = 0;
        for (int k = 0; k < 22; k++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            #1 if (cfg_active) act_cnt++;
        end
        chk("tmo owned cycles", act_cnt, 16);
        chk("tmo err", timeout_err, 1);
        chk("tmo locked", cfg_active, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("tmo regrant", cfg_active, 1);
        chk("tmo regrant owner", owner, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #1 chk("tmo cleared", timeout_err, 0);

        // Same-cycle owner and non-owner strobes
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 32'hA5A5A5A5, 1, 1, 32'h5A5A5A5A, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #1;
        chk("same data", bus.write_data, 32'hA5A5A5A5);
        chk("same drop", drop_err, 1);
        cyc(1, 0, 0, 1, 1, 32'h77, 1);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #1 chk("set beats clear", drop_err, 1);
        cyc(1, 0, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #1 chk("clear alone", drop_err, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-frame with a word in flight
        for (int i = 1; i <= 7; i++) cyc(1, 1, 32'h200 + i, 0, 0, 0, 0);
        cyc(1, 1, 32'h208, 0, 0, 0, 0);
        #2 resetn = 1'b0;
        #1 chk_all_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        bus.src0_strobe = 1'b0;
        resetn = 1'b1;
        cyc(1, 1, 32'h300, 0, 0, 0, 0);
        #1;
        chk("post reset grant", cfg_active, 1);
        chk("post reset index", bus.word_index, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post reset data", bus.write_data, 32'h300);
        chk("post reset index1", bus.word_index, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/config_source_arbiter.md
Name: config_source_arbiter

Overview:
- Shares the fabric's single configuration write port between two serial config front-ends: src0, the bitbang receiver (priority), and src1, the UART loader.
- Each front-end presents a one-cycle strobe, a 32-bit word and an active flag.
- The arbiter grants one source per session, forwards its words to the frame-loading FSM and tracks frame boundaries.
- It also enforces an inactivity timeout and records protocol errors.

Parameters:
- DATA_WIDTH, 32, config word width.
- FRAME_WORDS, 20, words per frame; must be at least 2.
- TIMEOUT_CYCLES, 65535, idle clocks with no owner strobe before forced release; 0 disables the timeout.

Ports:
- clk  in  1  config clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- src0_strobe  in  1  bitbang word-valid pulse.
- src0_data  in  DATA_WIDTH  bitbang word.
- src0_active  in  1  bitbang session flag.
- src1_strobe  in  1  UART word-valid pulse.
- src1_data  in  DATA_WIDTH  UART word.
- src1_active  in  1  UART session flag.
- err_clear  in  1  synchronous clear of the sticky error flags.
- write_strobe  out  1  one-cycle pulse per forwarded word.
- write_data  out  DATA_WIDTH  forwarded word; holds its value between strobes.
- frame_strobe  out  1  pulse coincident with write_strobe on the last word of each frame.
- word_index  out  clog2(FRAME_WORDS)  index within the frame of the next word to be forwarded.
- cfg_active  out  1  high while any source owns the port.
- owner  out  1  0 = src0 owns, 1 = src1 owns; valid only while cfg_active is high.
- drop_err  out  1  sticky: a non-owner strobe was discarded.
- timeout_err  out  1  sticky: the session was released by the timeout.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, all outputs 0, word_index 0, timeout counter 0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - src0_active high -> OWN0.
  - Otherwise src1_active high -> OWN1.
  - Both active in the same cycle -> OWN0.
  - A strobe from the winning source in the grant cycle is forwarded.
  - Strobes from a source whose active flag is low are ignored silently; no error is raised.
- OWNx:
  - Owner strobe -> next cycle write_strobe=1 and write_data=owner data. Latency is exactly 1 clk; the path is fully registered.
  - Non-owner strobe -> discarded and drop_err set.
  - If both strobe in the same cycle, the owner's word passes and drop_err is set.
- Release:
  - Owner active low -> IDLE next cycle.
  - An owner strobe in that same cycle is still forwarded.
  - The other source may be granted from IDLE the following cycle; there is no direct OWN0<->OWN1 transition.
- Frame tracking:
  - word_index increments on each forwarded word and wraps from FRAME_WORDS-1 to 0.
  - frame_strobe is asserted on the write_strobe of the word forwarded at index FRAME_WORDS-1.
  - word_index is forced to 0 on entry to IDLE, so a partial frame is abandoned without a frame_strobe.
- Timeout:
  - The counter clears on each owner strobe and on grant, and increments every other OWNx cycle.
  - On reaching TIMEOUT_CYCLES: -> IDLE, timeout_err set.
  - The timed-out source is not re-granted until its active flag has been observed low for at least one cycle; a per-source lockout bit clears when active is low.
- Sticky errors:
  - Cleared by err_clear or by reset.
  - If err_clear and a new error event occur in the same cycle, the set wins.
- cfg_active equals (state != IDLE) and is registered.
- owner is registered and changes only on grant.
- Reset mid-session: immediate IDLE; any in-flight write_strobe is lost.

Decomposition:
- Shared package cfg_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1};
  - source-ID constants SRC_BITBANG=0 and SRC_UART=1;
  - the default FRAME_WORDS and TIMEOUT_CYCLES constants, shared with the frame-loading FSM.
- One natural sub-module, cfg_frame_counter: holds word_index, generates frame_strobe, and takes clear/advance inputs.
- Timeout logic stays inline.

Test Plan:
- Basic forwarding: src0 active, strobes carrying 0x00000001..0x00000014 (FRAME_WORDS=20) -> 20 write_strobes each 1 clk after the input strobe, data matching; single frame_strobe on word 0x14; word_index back to 0.
- Priority: src0_active and src1_active rise in the same cycle -> owner=0. Then 3 src1 strobes -> no write_strobe, drop_err=1. err_clear -> drop_err=0.
- Handover: src0 sends 5 words, then deasserts active with a final strobe (0xDEADBEEF) in the same cycle -> 0xDEADBEEF forwarded. Next cycle IDLE, then grant to the waiting src1 (owner=1), word_index=0, no frame_strobe.
- Timeout: TIMEOUT_CYCLES=16, src1 granted with no strobes -> release after 16 clks, timeout_err=1. src1 kept active -> not re-granted. src1 active low for 1 clk then high -> re-granted.
- Same-cycle events: owner and non-owner strobe together with data 0xA5A5A5A5 (owner) and 0x5A5A5A5A -> write_data=0xA5A5A5A5, drop_err=1. err_clear coincident with another drop -> drop_err stays 1.
- Asynchronous reset mid-frame at word 7 -> all outputs 0 with no clk edge. After release, a new session starts at word_index 0.
